train_sample_feeder: RTL and testbench

Upstream stage of the crossbar training controller. Holds a small loadable table of training samples. Each sample is 4 feature bits plus a 3-bit label. The block presents the current sample on the controller's Xin0..Xin6 inputs and raises learn to start a training run. It advances to the next sample each time the controller finishes consuming one (the write_en pulse), and counts epochs and total updates until the run completes.

---
 rtl/train_sample_feeder_if.sv | 33 +++
 rtl/train_sample_feeder.sv | 165 ++++++++++++++++
 tb/tb_train_sample_feeder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/train_sample_feeder_if.sv
// Bus bundle between the training-sample feeder and its surroundings.
// Carries the table-load port, run control, the controller-facing
// sample strobe / feature-label word, and the run status counters.
// The feeder connects through the slave modport; the driver of loads,
// run control and write_en (controller or bench) uses the master modport.
interface train_sample_feeder_if #(
    parameter int FEAT_W  = 4,
    parameter int LABEL_W = 3
);
    logic                        load_en;
    logic [7:0]                  load_addr;
    logic [FEAT_W+LABEL_W-1:0]   load_data;
    logic                        start;
    logic                        abort;
    logic                        write_en;
    logic [FEAT_W+LABEL_W-1:0]   xin;
    logic                        learn;
    logic                        busy;
    logic                        done;
    logic [7:0]                  sample_idx;
    logic [15:0]                 epoch_cnt;
    logic [15:0]                 update_cnt;

    modport master (
        output load_en, load_addr, load_data, start, abort, write_en,
        input  xin, learn, busy, done, sample_idx, epoch_cnt, update_cnt
    );

    modport slave (
        input  load_en, load_addr, load_data, start, abort, write_en,
        output xin, learn, busy, done, sample_idx, epoch_cnt, update_cnt
    );
endinterface

// File: rtl/train_sample_feeder.sv
// Training-sample feeder for the crossbar training controller.
// Holds a loadable table of {features, label} samples, presents the current
// one on xin, requests a run with learn, and steps to the next sample each
// time the controller finishes capturing one (falling edge of write_en).
// Counts consumed samples and completed passes over the table until
// TRAIN_NUM updates have been made.
//
// Optional build macro SAMPLE_SHUFFLE_EN: permutes the presentation order
// each epoch with an 8-bit LFSR (NUM_SAMPLES must then be a power of two).
module train_sample_feeder #(
    parameter int NUM_SAMPLES = 8,
    parameter int TRAIN_NUM   = 1000,
    parameter int FEAT_W      = 4,
    parameter int LABEL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    train_sample_feeder_if.slave bus
);

    localparam int              SAMPLE_W      = FEAT_W + LABEL_W;
    localparam int              IDX_W         = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [8:0]      NUM_SAMPLES_9 = 9'(NUM_SAMPLES);
    localparam logic [7:0]      LAST_IDX      = 8'(NUM_SAMPLES - 1);
    localparam logic [15:0]     TRAIN_NUM_16  = 16'(TRAIN_NUM);

    typedef enum logic [1:0] {IDLE, ARM, FEED, DONE} state_t;

    state_t               state_q, state_d;
    logic [SAMPLE_W-1:0]  table_mem [NUM_SAMPLES];
    logic                 we_p1;
    logic [7:0]           idx_q, idx_d;
    logic [15:0]          epoch_q, epoch_d;
    logic [15:0]          upd_q, upd_d;
    logic [SAMPLE_W-1:0]  xin_q, xin_d;
    logic [IDX_W-1:0]     rd_addr;
    logic                 we_rise, we_fall, load_ok;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef SAMPLE_SHUFFLE_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    if ((NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0) begin : g_pow2_check
        $error("train_sample_feeder: NUM_SAMPLES must be a power of two with SAMPLE_SHUFFLE_EN");
    end

    // Permuted table address: sequential position XOR the epoch's LFSR state.
    assign rd_addr = idx_d[IDX_W-1:0] ^ lfsr_d[IDX_W-1:0];
`else
    assign rd_addr = idx_d[IDX_W-1:0];
`endif

    assign we_rise = bus.write_en & ~we_p1;
    assign we_fall = ~bus.write_en & we_p1;
    assign load_ok = (state_q == IDLE) && bus.load_en
                     && ({1'b0, bus.load_addr} < NUM_SAMPLES_9);

    // FSM state register; reset drops learn/busy at once since they decode state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and next counter values; abort outranks any write_en edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        upd_d   = upd_q;
`ifdef SAMPLE_SHUFFLE_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                    idx_d   = 8'd0;
                    epoch_d = 16'd0;
                    upd_d   = 16'd0;
`ifdef SAMPLE_SHUFFLE_EN
                    lfsr_d  = LFSR_SEED;
`endif
                end
            end
            ARM: begin
                if (bus.abort)    state_d = IDLE;
                else if (we_rise) state_d = FEED;
            end
            FEED: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (we_fall) begin
                    upd_d = upd_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 8'd0;
                        epoch_d = sat_inc16(epoch_q);
`ifdef SAMPLE_SHUFFLE_EN
                        lfsr_d  = lfsr_step(lfsr_q);
`endif
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                    if (upd_d == TRAIN_NUM_16) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Presented sample: table[0] while idle, otherwise the entry for the next index.
    always_comb begin
        xin_d = table_mem[rd_addr];
        if (state_d == IDLE) xin_d = table_mem[0];
    end

    // Counters, presented sample, and the write_en history used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1   <= 1'b0;
            idx_q   <= 8'd0;
            epoch_q <= 16'd0;
            upd_q   <= 16'd0;
            xin_q   <= '0;
        end else begin
            we_p1   <= bus.write_en;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            upd_q   <= upd_d;
            xin_q   <= xin_d;
        end
    end

`ifdef SAMPLE_SHUFFLE_EN
    // LFSR state, seeded at reset and again at every start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    // Sample table: storage only, never reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (load_ok) table_mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
    end

    assign bus.xin        = xin_q;
    assign bus.learn      = (state_q == ARM);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.sample_idx = idx_q;
    assign bus.epoch_cnt  = epoch_q;
    assign bus.update_cnt = upd_q;

endmodule

// File: tb/tb_train_sample_feeder.sv
// Directed bench for train_sample_feeder: table load, a full 20-update run,
// busy-time load/start rejection, abort, start+load, and mid-run reset.
// Expected values come from a small reference model kept in the bench.
module tb_train_sample_feeder;

    localparam int NS = 8;
    localparam int TN = 20;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    train_sample_feeder_if #(.FEAT_W(4), .LABEL_W(3)) bus ();

    train_sample_feeder #(
        .NUM_SAMPLES(NS),
        .TRAIN_NUM  (TN),
        .FEAT_W     (4),
        .LABEL_W    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [6:0]  tbl [NS];
    logic [7:0]  m_idx;
    logic [15:0] m_upd;
    logic [15:0] m_epoch;
`ifdef SAMPLE_SHUFFLE_EN
    logic [7:0]  m_lfsr;
`endif

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_xin();
`ifdef SAMPLE_SHUFFLE_EN
        return tbl[m_idx[2:0] ^ m_lfsr[2:0]];
`else
        return tbl[m_idx[2:0]];
`endif
    endfunction

    task automatic model_start();
        m_idx   = 8'd0;
        m_upd   = 16'd0;
        m_epoch = 16'd0;
`ifdef SAMPLE_SHUFFLE_EN
        m_lfsr  = 8'hA5;
`endif
    endtask

    task automatic model_consume();
        m_upd = m_upd + 16'd1;
        if (m_idx == 8'(NS - 1)) begin
            m_idx   = 8'd0;
            m_epoch = m_epoch + 16'd1;
`ifdef SAMPLE_SHUFFLE_EN
            m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        end else begin
            m_idx = m_idx + 8'd1;
        end
    endtask

    // Issue start and check the ARM-state outputs.
    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_start();
        check_val("busy_arm",  32'(bus.busy), 32'd1);
        check_val("learn_arm", 32'(bus.learn), 32'd1);
        check_val("upd_start", 32'(bus.update_cnt), 32'(m_upd));
        check_val("idx_start", 32'(bus.sample_idx), 32'd0);
        check_val("xin_arm",   32'(bus.xin), 32'(exp_xin()));
    endtask

    // One write_en pulse: 3 cycles high, then the falling edge is captured.
    task automatic feed_one();
        bus.write_en = 1'b1;
        tick();
        check_val("learn_drop", 32'(bus.learn), 32'd0);
        tick();
        tick();
        check_val("xin_hold", 32'(bus.xin), 32'(exp_xin()));
        bus.write_en = 1'b0;
        tick();
        model_consume();
        check_val("xin_next", 32'(bus.xin), 32'(exp_xin()));
        check_val("upd",      32'(bus.update_cnt), 32'(m_upd));
        check_val("idx",      32'(bus.sample_idx), 32'(m_idx));
        check_val("epoch",    32'(bus.epoch_cnt), 32'(m_epoch));
        check_val("done",     32'(bus.done), 32'(m_upd == 16'(TN)));
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = 8'd0;
        bus.load_data = 7'd0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.write_en  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_xin",   32'(bus.xin), 32'd0);
        check_val("rst_learn", 32'(bus.learn), 32'd0);
        check_val("rst_busy",  32'(bus.busy), 32'd0);
        check_val("rst_done",  32'(bus.done), 32'd0);
        check_val("rst_idx",   32'(bus.sample_idx), 32'd0);
        check_val("rst_epoch", 32'(bus.epoch_cnt), 32'd0);
        check_val("rst_upd",   32'(bus.update_cnt), 32'd0);
        #19 rst_n = 1'b1;
        tick();

        // Load table[i] = i, then an out-of-range address that must be dropped.
        for (int i = 0; i < NS; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 8'(i);
            bus.load_data = 7'(i);
            tbl[i]        = 7'(i);
            tick();
        end
        bus.load_addr = 8'd9;
        bus.load_data = 7'h55;
        tick();
        bus.load_en = 1'b0;
        tick();
        check_val("idle_xin", 32'(bus.xin), 32'(tbl[0]));

        // Full run: learn holds until the first write_en rise, then 20 updates.
        start_run();
        tick();
        tick();
        check_val("learn_wait", 32'(bus.learn), 32'd1);
        for (int k = 0; k < TN; k++) begin
            feed_one();
            if (k == 1) begin
                // Load and start while busy must both be ignored.
                bus.load_en   = 1'b1;
                bus.load_addr = 8'd3;
                bus.load_data = 7'h7F;
                bus.start     = 1'b1;
                tick();
                bus.load_en   = 1'b0;
                bus.start     = 1'b0;
                repeat (5) tick();
            end else if (k != TN - 1) begin
                repeat (6) tick();
            end
        end
        tick();
        check_val("end_done",  32'(bus.done), 32'd0);
        check_val("end_busy",  32'(bus.busy), 32'd0);
        check_val("end_upd",   32'(bus.update_cnt), 32'd20);
        check_val("end_epoch", 32'(bus.epoch_cnt), 32'd2);
        check_val("end_idx",   32'(bus.sample_idx), 32'd4);
        check_val("done_once", 32'(done_cnt), 32'd1);

        // write_en activity while idle is ignored.
        bus.write_en = 1'b1;
        tick();
        tick();
        bus.write_en = 1'b0;
        tick();
        tick();
        check_val("idle_we_upd",  32'(bus.update_cnt), 32'd20);
        check_val("idle_we_busy", 32'(bus.busy), 32'd0);
        check_val("idle_xin2",    32'(bus.xin), 32'(tbl[0]));

        // Abort run: abort lands on the same edge as the 6th falling edge.
        start_run();
        for (int k = 0; k < 5; k++) begin
            feed_one();
            repeat (6) tick();
        end
        bus.write_en = 1'b1;
        repeat (3) tick();
        bus.write_en = 1'b0;
        bus.abort    = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_val("abort_busy",  32'(bus.busy), 32'd0);
        check_val("abort_learn", 32'(bus.learn), 32'd0);
        check_val("abort_done",  32'(bus.done), 32'd0);
        check_val("abort_upd",   32'(bus.update_cnt), 32'd5);
        check_val("abort_idx",   32'(bus.sample_idx), 32'd5);
        tick();
        tick();
        check_val("abort_upd2",  32'(bus.update_cnt), 32'd5);
        check_val("abort_dcnt",  32'(done_cnt), 32'd1);

        // start together with a load: the load lands, then the run arms.
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd0;
        bus.load_data = 7'h2A;
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        tbl[0]      = 7'h2A;
        model_start();
        check_val("sl_busy", 32'(bus.busy), 32'd1);
        check_val("sl_upd",  32'(bus.update_cnt), 32'd0);
        check_val("sl_idx",  32'(bus.sample_idx), 32'd0);
        tick();
        check_val("sl_xin",  32'(bus.xin), 32'(exp_xin()));
        for (int k = 0; k < 2; k++) begin
            feed_one();
            repeat (6) tick();
        end

        // Reset in the middle of FEED clears everything without a clock edge.
        bus.write_en = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("mrst_xin",   32'(bus.xin), 32'd0);
        check_val("mrst_learn", 32'(bus.learn), 32'd0);
        check_val("mrst_busy",  32'(bus.busy), 32'd0);
        check_val("mrst_idx",   32'(bus.sample_idx), 32'd0);
        check_val("mrst_upd",   32'(bus.update_cnt), 32'd0);
        check_val("mrst_epoch", 32'(bus.epoch_cnt), 32'd0);
        bus.write_en = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check_val("post_rst_xin", 32'(bus.xin), 32'(tbl[0]));
        start_run();
        feed_one();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
